// File: rtl/pix_pkg.sv
// Shared types and default geometry for the pixel ping-pong buffer write path.
// Both the packer and the buffer controller build against these constants.
package pix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } pix_pack_state_t;

  localparam int unsigned VA_DEFAULT = 500;
  localparam int unsigned PIX_ADDR_W = 9;
  localparam int unsigned PIX_DATA_W = 509;
  localparam int unsigned PIX_SEG_W  = 64;

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pix_row_packer.sv
// Packs NSEG narrow pixel segments into one row word and writes VA rows per bank,
// then hands the bank to the reader with a single done pulse.
module pix_row_packer
  import pix_pkg::*;
#(
  parameter int unsigned VA         = VA_DEFAULT,
  parameter int unsigned ADDR_WIDTH = PIX_ADDR_W,
  parameter int unsigned DATA_WIDTH = PIX_DATA_W,
  parameter int unsigned SEG_W      = PIX_SEG_W
) (
  input  logic                  clk_i,
  input  logic                  resetz_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [SEG_W-1:0]      in_data_i,
  input  logic                  in_last_i,
  input  logic                  pp_ram_full_i,
  output logic [ADDR_WIDTH-1:0] pix_waddr_o,
  output logic [DATA_WIDTH-1:0] pix_wdata_o,
  output logic                  pix_wr_o,
  output logic                  pp_ram_wr_done_o,
  output logic                  frame_busy_o,
  output logic                  err_o
);

  localparam int unsigned NSEG      = (DATA_WIDTH + SEG_W - 1) / SEG_W;
  localparam int unsigned SEG_CNT_W = clog2_min1(NSEG);
  localparam int unsigned SEG_IDX_W = clog2_min1(SEG_W);
  localparam int unsigned ROW_IDX_W = clog2_min1(DATA_WIDTH);

  localparam logic [SEG_CNT_W-1:0]  SEG_LAST = SEG_CNT_W'(NSEG - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(VA - 1);

  pix_pack_state_t r_state;
  pix_pack_state_t w_next_state;

  logic [SEG_CNT_W-1:0]  r_seg_cnt;
  logic [ADDR_WIDTH-1:0] r_row_cnt;
  logic [DATA_WIDTH-1:0] r_row;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_wr;
  logic                  r_done;
  logic                  r_err;

  logic                  w_in_ready;
  logic                  w_frame_busy;
  logic                  w_accept;
  logic                  w_seg_last;
  logic                  w_row_last;
  logic [DATA_WIDTH-1:0] w_row_next;

  assign w_accept   = in_valid_i & w_in_ready;
  assign w_seg_last = (r_seg_cnt == SEG_LAST);
  assign w_row_last = (r_row_cnt == ROW_LAST);

  // State register
  always_ff @(posedge clk_i or negedge resetz_i) begin
    if (!resetz_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; the segment counter, not in_last_i, closes a row.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (!pp_ram_full_i) w_next_state = FILL;
      FILL:    if (w_accept && w_seg_last) w_next_state = WRITE;
      WRITE:   w_next_state = w_row_last ? DONE : FILL;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_in_ready   = 1'b0;
    w_frame_busy = 1'b1;
    unique case (r_state)
      IDLE:    w_frame_busy = 1'b0;
      FILL:    w_in_ready   = 1'b1;
      WRITE:   w_in_ready   = 1'b0;
      DONE:    w_in_ready   = 1'b0;
      default: w_frame_busy = 1'b0;
    endcase
  end

  // Merge the incoming segment into its slot; bits past DATA_WIDTH are never
  // generated, which drops the overhang of the final segment.
  always_comb begin
    w_row_next = r_row;
    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
      if (r_seg_cnt == SEG_CNT_W'(b / SEG_W)) begin
        w_row_next[ROW_IDX_W'(b)] = in_data_i[SEG_IDX_W'(b % SEG_W)];
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetz_i) begin
    if (!resetz_i) begin
      r_seg_cnt <= '0;
      r_row     <= '0;
    end else if (w_accept) begin
      r_row     <= w_row_next;
      r_seg_cnt <= w_seg_last ? '0 : r_seg_cnt + SEG_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetz_i) begin
    if (!resetz_i) begin
      r_row_cnt <= '0;
    end else if (r_state == WRITE) begin
      r_row_cnt <= w_row_last ? '0 : r_row_cnt + ADDR_WIDTH'(1);
    end
  end

  // Write port is loaded on the closing accept so the strobe lands in WRITE.
  always_ff @(posedge clk_i or negedge resetz_i) begin
    if (!resetz_i) begin
      r_wr    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wr <= w_accept & w_seg_last;
      if (w_accept && w_seg_last) begin
        r_waddr <= r_row_cnt;
        r_wdata <= w_row_next;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetz_i) begin
    if (!resetz_i) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      r_err  <= w_accept & (in_last_i ^ w_seg_last);
    end
  end

  assign in_ready_o       = w_in_ready;
  assign frame_busy_o     = w_frame_busy;
  assign pix_waddr_o      = r_waddr;
  assign pix_wdata_o      = r_wdata;
  assign pix_wr_o         = r_wr;
  assign pp_ram_wr_done_o = r_done;
  assign err_o            = r_err;

endmodule

// File: tb/tb_pix_row_packer.sv
// Directed bench for pix_row_packer: full frames, stalls, valid gaps,
// in_last disagreement, mid-frame reset and late full assertion.
module tb_pix_row_packer;

  localparam int VA   = 500;
  localparam int AW   = 9;
  localparam int DW   = 509;
  localparam int SW   = 64;
  localparam int NSEG = 8;

  logic          clk;
  logic          resetz;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_data;
  logic          in_last;
  logic          pp_full;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wr;
  logic          done;
  logic          busy;
  logic          err;

  pix_row_packer #(
    .VA(VA),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .SEG_W(SW)
  ) dut (
    .clk_i(clk),
    .resetz_i(resetz),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .in_data_i(in_data),
    .in_last_i(in_last),
    .pp_ram_full_i(pp_full),
    .pix_waddr_o(waddr),
    .pix_wdata_o(wdata),
    .pix_wr_o(wr),
    .pp_ram_wr_done_o(done),
    .frame_busy_o(busy),
    .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  bit drv_timeout;

  int            cyc;
  int            wq_addr[$];
  logic [DW-1:0] wq_data[$];
  int            wq_cyc[$];
  int            dq_cyc[$];
  int            eq_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (wr) begin
      wq_addr.push_back(int'(waddr));
      wq_data.push_back(wdata);
      wq_cyc.push_back(cyc);
    end
    if (done) dq_cyc.push_back(cyc);
    if (err)  eq_cyc.push_back(cyc);
  end

  function automatic logic [SW-1:0] seg_val(input int r, input int s);
    logic [7:0] hi;
    hi = 8'hF0 ^ 8'(s);
    return {hi, 24'(r), 16'hC3A5, 8'(s), 8'(r)};
  endfunction

  function automatic logic [DW-1:0] exp_row(input int r);
    logic [NSEG*SW-1:0] w;
    for (int s = 0; s < NSEG; s++) w[s*SW +: SW] = seg_val(r, s);
    return w[DW-1:0];
  endfunction

  task automatic clear_logs();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    dq_cyc.delete();
    eq_cyc.delete();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && dq_cyc.size() == 0; i++) @(negedge clk);
    wait_cycles(4);
  endtask

  // Called at a negedge; returns at the negedge after the segment is accepted.
  task automatic offer_seg(input int r, input int s, input bit last, input int gap_pct);
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = seg_val(r, s);
    in_last  = last;
    for (int w = 0; w < 64; w++) begin
      if (in_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    vectors++;
    miscompares++;
    $display("FAIL seg_accept_timeout row %0d seg %0d: got no ready in 64 cycles, want ready", r, s);
    drv_timeout = 1'b1;
  endtask

  task automatic drive_frame(input int gap_pct, input int err_row, input int full_row,
                             input int abort_row);
    for (int r = 0; r < VA; r++) begin
      for (int s = 0; s < NSEG; s++) begin
        if (r == abort_row && s == 4) return;
        if (drv_timeout) return;
        if (r == full_row && s == 2) pp_full = 1'b1;
        offer_seg(r, s, (s == NSEG - 1) || (r == err_row && s == 3), gap_pct);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    resetz   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    pp_full  = 1'b1;
    wait_cycles(3);
    vectors++;
    if ({wr, done, err, in_ready, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, want 00000", {wr, done, err, in_ready, busy});
    end
    vectors++;
    if (waddr !== '0) begin
      miscompares++;
      $display("FAIL reset_waddr: got %0d, want 0", waddr);
    end
    vectors++;
    if (wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_wdata: got %h, want 0", wdata);
    end
    resetz = 1'b1;
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_idle[%0d]: got ready %b busy %b, want 0 0", i, in_ready, busy);
      end
    end
    pp_full = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got ready %b busy %b, want 1 1", in_ready, busy);
    end
  endtask

  task automatic test_continuous();
    logic [DW-1:0] w_last;
    logic [SW-1:0] s7;
    int n;
    clear_logs();
    drive_frame(0, -1, -1, -1);
    wait_done();
    n = (wq_addr.size() < VA) ? wq_addr.size() : VA;
    vectors++;
    if (wq_addr.size() != VA) begin
      miscompares++;
      $display("FAIL cont_write_count: got %0d, want %0d", wq_addr.size(), VA);
    end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (wq_addr[i] != i || wq_data[i] !== exp_row(i)) begin
        miscompares++;
        $display("FAIL cont_row[%0d]: got addr %0d data %h, want addr %0d data %h",
                 i, wq_addr[i], wq_data[i], i, exp_row(i));
      end
      if (i > 0) begin
        vectors++;
        if (wq_cyc[i] - wq_cyc[i-1] != NSEG + 1) begin
          miscompares++;
          $display("FAIL cont_spacing[%0d]: got %0d cycles, want %0d",
                   i, wq_cyc[i] - wq_cyc[i-1], NSEG + 1);
        end
      end
    end
    if (n == VA) begin
      w_last = wq_data[VA-1];
      s7 = seg_val(VA - 1, 7);
      vectors++;
      if (w_last[508:448] !== s7[60:0]) begin
        miscompares++;
        $display("FAIL cont_row499_top: got %h, want %h", w_last[508:448], s7[60:0]);
      end
    end
    vectors++;
    if (dq_cyc.size() != 1 || n == 0) begin
      miscompares++;
      $display("FAIL cont_done_count: got %0d, want 1", dq_cyc.size());
    end else begin
      vectors++;
      if (dq_cyc[0] != wq_cyc[n-1] + 2) begin
        miscompares++;
        $display("FAIL cont_done_delay: got %0d cycles, want 2", dq_cyc[0] - wq_cyc[n-1]);
      end
    end
    vectors++;
    if (eq_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL cont_err_count: got %0d, want 0", eq_cyc.size());
    end
  endtask

  task automatic test_valid_gaps();
    int n;
    clear_logs();
    drive_frame(50, -1, -1, -1);
    wait_done();
    wait_cycles(20);
    n = (wq_addr.size() < VA) ? wq_addr.size() : VA;
    vectors++;
    if (wq_addr.size() != VA) begin
      miscompares++;
      $display("FAIL gap_write_count: got %0d, want %0d", wq_addr.size(), VA);
    end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (wq_addr[i] != i || wq_data[i] !== exp_row(i)) begin
        miscompares++;
        $display("FAIL gap_row[%0d]: got addr %0d data %h, want addr %0d data %h",
                 i, wq_addr[i], wq_data[i], i, exp_row(i));
      end
    end
    vectors++;
    if (dq_cyc.size() != 1 || eq_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL gap_done_err: got done %0d err %0d, want 1 0", dq_cyc.size(), eq_cyc.size());
    end
  endtask

  task automatic test_last_mismatch();
    clear_logs();
    drive_frame(0, 10, -1, -1);
    wait_done();
    vectors++;
    if (wq_addr.size() != VA || dq_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL lm_frame: got writes %0d done %0d, want %0d 1",
               wq_addr.size(), dq_cyc.size(), VA);
    end
    vectors++;
    if (eq_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL lm_err_count: got %0d, want 1", eq_cyc.size());
    end else if (wq_cyc.size() > 11) begin
      vectors++;
      if (eq_cyc[0] != wq_cyc[10] - 4) begin
        miscompares++;
        $display("FAIL lm_err_time: got write-%0d, want write-4", wq_cyc[10] - eq_cyc[0]);
      end
    end
    if (wq_addr.size() > 11) begin
      for (int i = 10; i <= 11; i++) begin
        vectors++;
        if (wq_addr[i] != i || wq_data[i] !== exp_row(i)) begin
          miscompares++;
          $display("FAIL lm_row[%0d]: got addr %0d data %h, want addr %0d data %h",
                   i, wq_addr[i], wq_data[i], i, exp_row(i));
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    clear_logs();
    drive_frame(0, -1, -1, 200);
    #2;
    resetz   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    vectors++;
    if ({wr, done, err, in_ready, busy} !== 5'b0 || waddr !== '0 || wdata !== '0) begin
      miscompares++;
      $display("FAIL midreset_async: got ctrl %b addr %0d data %h, want 00000 0 0",
               {wr, done, err, in_ready, busy}, waddr, wdata);
    end
    @(negedge clk);
    @(negedge clk);
    resetz = 1'b1;
    wait_cycles(20);
    vectors++;
    if (wq_addr.size() != 200 || dq_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_abandon: got writes %0d done %0d, want 200 0",
               wq_addr.size(), dq_cyc.size());
    end
    clear_logs();
    drive_frame(0, -1, -1, -1);
    wait_done();
    n = (wq_addr.size() < VA) ? wq_addr.size() : VA;
    vectors++;
    if (wq_addr.size() != VA || dq_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL midreset_next_frame: got writes %0d done %0d, want %0d 1",
               wq_addr.size(), dq_cyc.size(), VA);
    end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (wq_addr[i] != i || wq_data[i] !== exp_row(i)) begin
        miscompares++;
        $display("FAIL midreset_row[%0d]: got addr %0d data %h, want addr %0d data %h",
                 i, wq_addr[i], wq_data[i], i, exp_row(i));
      end
    end
  endtask

  task automatic test_full_midframe();
    int n;
    clear_logs();
    drive_frame(0, -1, 300, -1);
    wait_done();
    n = wq_addr.size();
    vectors++;
    if (n != VA || dq_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL fullmid_frame: got writes %0d done %0d, want %0d 1", n, dq_cyc.size(), VA);
    end else begin
      vectors++;
      if (wq_addr[VA-1] != VA - 1 || dq_cyc[0] != wq_cyc[VA-1] + 2) begin
        miscompares++;
        $display("FAIL fullmid_tail: got addr %0d done delay %0d, want %0d 2",
                 wq_addr[VA-1], dq_cyc[0] - wq_cyc[VA-1], VA - 1);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL fullmid_hold[%0d]: got ready %b busy %b, want 0 0", i, in_ready, busy);
      end
    end
    pp_full = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    drv_timeout = 1'b0;
    cyc         = 0;
    test_reset();
    test_full_stall();
    test_continuous();
    test_valid_gaps();
    test_last_mismatch();
    test_reset_midframe();
    test_full_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
